// File: rtl/deng_alu_inv.sv
// Bit-serial inverse of Y = (A+2) ^ (A+B): recovers B = (Y ^ (A+2)) - A, one bit per cycle LSB first.
// Start/busy/done handshake with a held result register; cancel aborts without committing.
module deng_alu_inv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             cancel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] B
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] sa, sy, wb;
  logic [CW-1:0]    cnt;
  logic             c, br;

  logic a_i, y_i, k, t, c_nxt, x, b_i, br_nxt, last, launch;

  // One full-adder slice rebuilds bit i of A+2, one full-subtractor slice peels off A.
  assign a_i    = sa[0];
  assign y_i    = sy[0];
  assign k      = (cnt == CW'(1));
  assign t      = a_i ^ k ^ c;
  assign c_nxt  = (a_i & k) | (a_i & c) | (k & c);
  assign x      = y_i ^ t;
  assign b_i    = x ^ a_i ^ br;
  assign br_nxt = (~x & a_i) | (~(x ^ a_i) & br);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign launch = (state == IDLE) && start && !cancel;
  assign busy   = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !cancel) state_nxt = RUN;
      RUN:  if (cancel || last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa   <= '0;
      sy   <= '0;
      wb   <= '0;
      cnt  <= '0;
      c    <= 1'b0;
      br   <= 1'b0;
      B    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        sa  <= A;
        sy  <= Y;
        wb  <= '0;
        cnt <= '0;
        c   <= 1'b0;
        br  <= 1'b0;
      end else if (state == RUN && !cancel) begin
        sa  <= sa >> 1;
        sy  <= sy >> 1;
        wb  <= {b_i, wb[WIDTH-1:1]};
        cnt <= cnt + CW'(1);
        c   <= c_nxt;
        br  <= br_nxt;
        // Carry and borrow out of the MSB fall away here: arithmetic is mod 2^WIDTH.
        if (last) begin
          B    <= {b_i, wb[WIDTH-1:1]};
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_deng_alu_inv.sv
// Directed and randomized checks of deng_alu_inv at WIDTH=32 plus a WIDTH=8 instance.
module tb_deng_alu_inv;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, cancel = 1'b0;
  logic [31:0] a = '0, y = '0, b;
  logic busy, done;
  logic start8 = 1'b0, cancel8 = 1'b0;
  logic [7:0] a8 = '0, y8 = '0, b8;
  logic busy8, done8;

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  deng_alu_inv #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cancel(cancel),
    .A(a), .Y(y), .busy(busy), .done(done), .B(b)
  );

  deng_alu_inv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .cancel(cancel8),
    .A(a8), .Y(y8), .busy(busy8), .done(done8), .B(b8)
  );

  // Drives a one-cycle start; returns at the negedge of cycle 1.
  task automatic launch(input logic [31:0] av, input logic [31:0] yv);
    start = 1'b1; a = av; y = yv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; cyc is the cycle done was seen, bc the busy cycles observed.
  task automatic wait_done(output int cyc, output int bc);
    cyc = 1; bc = 0;
    forever begin
      if (busy) bc++;
      if (done || cyc >= 200) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    #12;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || b !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b B=%h, need 0 0 00000000", busy, done, b);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc, bc;
    launch(32'd5, 32'h0000000F);
    wait_done(cyc, bc);
    n_vec++;
    if (cyc != 33 || bc != 32) begin
      n_fail++;
      $display("FAIL basic_latency: done cycle %0d busy cycles %0d, need 33 32", cyc, bc);
    end
    n_vec++;
    if (b !== 32'h3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: B=%h busy=%b, need 00000003 0", b, busy);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || b !== 32'h3) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%b B=%h, need 0 00000003", done, b);
    end
  endtask

  task automatic test_wrap;
    int cyc, bc;
    logic [31:0] av [3] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0};
    logic [31:0] yv [3] = '{32'h00000001, 32'h12345676, 32'h2};
    logic [31:0] ev [3] = '{32'h00000001, 32'h12345678, 32'h0};
    for (int i = 0; i < 3; i++) begin
      launch(av[i], yv[i]);
      wait_done(cyc, bc);
      n_vec++;
      if (cyc != 33 || b !== ev[i]) begin
        n_fail++;
        $display("FAIL wrap_%0d: B=%h cycle %0d, need %h cycle 33", i, b, cyc, ev[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_handshake;
    int cyc, bc, ndone;
    launch(32'd5, 32'h0000000F);
    cyc = 1; ndone = 0;
    while (cyc < 33) begin
      start = (cyc == 3 || cyc == 20);
      a = 32'h11111111; y = 32'h22222222;
      @(negedge clk);
      cyc++;
      if (done) ndone++;
    end
    start = 1'b0;
    n_vec++;
    if (ndone != 1 || done !== 1'b1 || b !== 32'h3) begin
      n_fail++;
      $display("FAIL start_ignored: dones=%0d done=%b B=%h, need 1 1 00000003", ndone, done, b);
    end
    // Launch in the done cycle: back-to-back op.
    launch(32'hFFFFFFFF, 32'h1);
    n_vec++;
    if (busy !== 1'b1 || b !== 32'h3) begin
      n_fail++;
      $display("FAIL back_to_back_hold: busy=%b B=%h, need 1 00000003", busy, b);
    end
    wait_done(cyc, bc);
    n_vec++;
    if (cyc != 33 || b !== 32'h1) begin
      n_fail++;
      $display("FAIL back_to_back: B=%h cycle %0d, need 00000001 cycle 33", b, cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_cancel;
    int cyc, ndone;
    launch(32'hFFFFFFFE, 32'h12345676);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_mid_busy: busy=%b, need 0", busy);
    end
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    n_vec++;
    if (ndone != 0 || b !== 32'h1) begin
      n_fail++;
      $display("FAIL cancel_mid_result: dones=%0d B=%h, need 0 00000001", ndone, b);
    end
    // Cancel landing on the commit edge.
    launch(32'hFFFFFFFE, 32'h12345676);
    repeat (31) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || b !== 32'h1) begin
      n_fail++;
      $display("FAIL cancel_commit: busy=%b done=%b B=%h, need 0 0 00000001", busy, done, b);
    end
    // Cancel together with start in IDLE.
    start = 1'b1; cancel = 1'b1; a = 32'd5; y = 32'hF;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    ndone = (busy === 1'b1) ? 1 : 0;
    repeat (40) begin @(negedge clk); if (done || busy) ndone++; end
    n_vec++;
    if (ndone != 0 || b !== 32'h1) begin
      n_fail++;
      $display("FAIL cancel_start_idle: activity=%0d B=%h, need 0 00000001", ndone, b);
    end
    launch(32'hFFFFFFFE, 32'h12345676);
    wait_done(cyc, ndone);
    n_vec++;
    if (cyc != 33 || b !== 32'h12345678) begin
      n_fail++;
      $display("FAIL after_cancel: B=%h cycle %0d, need 12345678 cycle 33", b, cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    int cyc, bc;
    launch(32'd0, 32'h2);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || b !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_midrun: busy=%b done=%b B=%h, need 0 0 00000000", busy, done, b);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    launch(32'd5, 32'hF);
    wait_done(cyc, bc);
    n_vec++;
    if (cyc != 33 || b !== 32'h3) begin
      n_fail++;
      $display("FAIL after_reset: B=%h cycle %0d, need 00000003 cycle 33", b, cyc);
    end
  endtask

  task automatic test_random32;
    int cyc, bc;
    logic [31:0] av, b0;
    for (int i = 0; i < 300; i++) begin
      av = $urandom; b0 = $urandom;
      if (i == 0) begin av = 32'hFFFFFFFF; b0 = 32'hFFFFFFFF; end
      launch(av, (av + 32'd2) ^ (av + b0));
      wait_done(cyc, bc);
      n_vec++;
      if (cyc != 33 || b !== b0) begin
        n_fail++;
        $display("FAIL random32 A=%h: B=%h cycle %0d, need %h cycle 33", av, b, cyc, b0);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random8;
    int cyc;
    logic [7:0] av, b0;
    for (int i = 0; i < 1500; i++) begin
      av = 8'($urandom); b0 = 8'($urandom);
      if (i < 4) begin av = 8'hFE + 8'(i); b0 = 8'hFF - 8'(i); end
      start8 = 1'b1; a8 = av; y8 = (av + 8'd2) ^ (av + b0);
      @(negedge clk);
      start8 = 1'b0;
      cyc = 1;
      while (!done8 && cyc < 50) begin @(negedge clk); cyc++; end
      n_vec++;
      if (cyc != 9 || b8 !== b0) begin
        n_fail++;
        $display("FAIL random8 A=%h: B=%h cycle %0d, need %h cycle 9", av, b8, cyc, b0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_handshake();
    test_cancel();
    test_reset_midrun();
    test_random32();
    test_random8();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
